// File: rtl/interleaver_pkg.sv
// Shared constants and FSM state encoding for the QPP interleaver address sequencer.
package interleaver_pkg;
    localparam int KW    = 13;
    localparam int CW    = 10;
    localparam int K_MIN = 40;
    localparam int K_MAX = 6144;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        RUN,
        DONE
    } ilv_state_t;
endpackage

// File: rtl/generaldff.sv
// Generic register with asynchronous active-high reset to a constant value.
module generaldff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end
endmodule

// File: rtl/ilv_k_check.sv
// Combinational block-length legality check: multiple of 8 within [K_MIN, K_MAX].
module ilv_k_check
    import interleaver_pkg::*;
#(
    parameter int KW = interleaver_pkg::KW
) (
    input  logic [KW-1:0] k,
    output logic          legal
);
    assign legal = (k[2:0] == 3'b000) &&
                   (k >= KW'(K_MIN)) &&
                   (k <= KW'(K_MAX));
endmodule

// File: rtl/interleaver_ctrl.sv
// Sequencer for the two-stage QPP interleaver address datapath.
// Optional abort support is compiled in when ILV_ABORT_EN is defined.
module interleaver_ctrl
    import interleaver_pkg::*;
#(
    parameter int KW         = interleaver_pkg::KW,
    parameter int CW         = interleaver_pkg::CW,
    parameter int STAGE1_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
`ifdef ILV_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    input  logic          start,
    input  logic [KW-1:0] K_in,
    output logic [KW-1:0] K_i,
    output logic [CW-1:0] counter_r,
    output logic          dff_clr,
    output logic          busy,
    output logic          pi_valid,
    output logic [CW-1:0] pi_beat,
    output logic          pi_last,
    output logic          done,
    output logic          k_err
);
    ilv_state_t    state_reg, state_next;
    logic [KW-1:0] k_reg;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    wait_reg, wait_next;
    logic          k_err_reg;
    logic          k_legal;
    logic [CW-1:0] last_cnt;
    logic          tc;
    logic          abort_hit;
    logic          accept;

    ilv_k_check #(.KW(KW)) u_k_check (
        .k     (K_in),
        .legal (k_legal)
    );

    // K/8 always fits CW bits for legal K, so the compare stays 10-bit.
    assign last_cnt = CW'(k_reg >> 3) - CW'(1);
    assign tc       = (state_reg == RUN) && (cnt_reg == last_cnt);
    assign accept   = (state_reg == IDLE) && start;

`ifdef ILV_ABORT_EN
    logic aborted_reg;
    assign abort_hit = abort && ((state_reg == LOAD) || (state_reg == WAIT) || (state_reg == RUN));
    assign aborted   = aborted_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) aborted_reg <= 1'b0;
        else     aborted_reg <= abort_hit;
    end
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wait_next  = wait_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (start && k_legal) state_next = LOAD;
            end
            LOAD: begin
                wait_next  = 3'(STAGE1_LAT - 1);
                state_next = WAIT;
            end
            WAIT: begin
                if (wait_reg == 3'd0) state_next = RUN;
                else                  wait_next  = wait_reg - 3'd1;
            end
            RUN: begin
                if (tc) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
        // Abort overrides every transition, including the terminal count.
        if (abort_hit) begin
            cnt_next   = '0;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            wait_reg  <= '0;
            k_reg     <= '0;
            k_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            wait_reg  <= wait_next;
            k_err_reg <= accept && !k_legal;
            if (accept && k_legal) k_reg <= K_in;
        end
    end

    assign K_i       = k_reg;
    assign counter_r = cnt_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign k_err     = k_err_reg;
    assign dff_clr   = (state_reg == IDLE) || (state_reg == LOAD) || (state_reg == DONE);

    // Stage 2 registers its Pi result, so qualifiers trail counter_r by one cycle.
    generaldff #(.W(CW + 2)) u_pi_pipe (
        .clk (clk),
        .rst (rst),
        .d   ({(state_reg == RUN) && !abort_hit, cnt_reg, tc && !abort_hit}),
        .q   ({pi_valid, pi_beat, pi_last})
    );
endmodule

// File: tb/tb_interleaver_ctrl.sv
// Directed, table-driven bench for interleaver_ctrl (abort checks when ILV_ABORT_EN is defined).
`timescale 1ns/1ps
module tb_interleaver_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [12:0] K_in = '0;
    logic [12:0] K_i;
    logic [9:0]  counter_r;
    logic        dff_clr, busy, pi_valid, pi_last, done, k_err;
    logic [9:0]  pi_beat;
`ifdef ILV_ABORT_EN
    logic abort = 1'b0;
    logic aborted;
`endif

    int n_checks = 0;
    int n_errs   = 0;

    interleaver_ctrl dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ILV_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .start     (start),
        .K_in      (K_in),
        .K_i       (K_i),
        .counter_r (counter_r),
        .dff_clr   (dff_clr),
        .busy      (busy),
        .pi_valid  (pi_valid),
        .pi_beat   (pi_beat),
        .pi_last   (pi_last),
        .done      (done),
        .k_err     (k_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic busy;
        logic clr;
        int   cnt;
        logic pv;
        int   pb;
        logic pl;
        logic dn;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [12:0] k);
        K_in  = k;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Walks a run until done; optionally pulses start with poke_k when beat poke_beat is visible.
    task automatic run_to_done(input int budget, input int k_exp, input int poke_beat,
                               input logic [12:0] poke_k,
                               output int beats, output int last_beat, output int max_cnt,
                               output int bad, output bit got_done);
        beats = 0; last_beat = -1; max_cnt = 0; bad = 0; got_done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            start = 1'b0;
            if (int'(counter_r) > max_cnt) max_cnt = int'(counter_r);
            if (int'(K_i) != k_exp) bad++;
            if (k_err) bad++;
            if (pi_valid) begin
                if (int'(pi_beat) != beats) bad++;
                beats++;
                last_beat = int'(pi_beat);
                if (int'(pi_beat) == poke_beat) begin
                    start = 1'b1;
                    K_in  = poke_k;
                end
            end
            if (done) begin
                got_done = 1'b1;
                if (!(pi_last && pi_valid)) bad++;
                break;
            end
            if (pi_last) bad++;
            step();
        end
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_K_i"},       32'(K_i),       32'd0);
        chk({tag, "_counter_r"}, 32'(counter_r), 32'd0);
        chk({tag, "_dff_clr"},   32'(dff_clr),   32'd1);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_pi_valid"},  32'(pi_valid),  32'd0);
        chk({tag, "_pi_beat"},   32'(pi_beat),   32'd0);
        chk({tag, "_pi_last"},   32'(pi_last),   32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_k_err"},     32'(k_err),     32'd0);
    endtask

    initial begin
        int  beats, last_beat, max_cnt, bad;
        bit  got_done, found;

        // K=40 timeline, cycles 1..10 after the start cycle.
        tbl[0] = '{1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1, 1'b1, 0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 2, 1'b1, 1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 3, 1'b1, 2, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 4, 1'b1, 3, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 0, 1'b1, 4, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0};

        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        step();
        step();
        rst = 1'b0;
        step();

        // K=40 cycle-accurate timeline
        launch(13'd40);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("k40_busy_c%0d", i + 1),    32'(busy),      32'(tbl[i].busy));
            chk($sformatf("k40_clr_c%0d", i + 1),     32'(dff_clr),   32'(tbl[i].clr));
            chk($sformatf("k40_cnt_c%0d", i + 1),     32'(counter_r), 32'(tbl[i].cnt));
            chk($sformatf("k40_pv_c%0d", i + 1),      32'(pi_valid),  32'(tbl[i].pv));
            if (tbl[i].pv)
                chk($sformatf("k40_pb_c%0d", i + 1),  32'(pi_beat),   32'(tbl[i].pb));
            chk($sformatf("k40_pl_c%0d", i + 1),      32'(pi_last),   32'(tbl[i].pl));
            chk($sformatf("k40_done_c%0d", i + 1),    32'(done),      32'(tbl[i].dn));
            step();
        end
        $display("run K=40 timeline checked");

        // K=6144: full-length run
        launch(13'd6144);
        run_to_done(2000, 6144, -1, 13'd0, beats, last_beat, max_cnt, bad, got_done);
        chk("k6144_done_seen", 32'(got_done), 32'd1);
        chk("k6144_beats",     32'(beats),     32'd768);
        chk("k6144_last_beat", 32'(last_beat), 32'd767);
        chk("k6144_max_cnt",   32'(max_cnt),   32'd767);
        chk("k6144_seq_bad",   32'(bad),       32'd0);
        $display("run K=6144 beats=%0d last=%0d", beats, last_beat);
        step();

        // Illegal K values
        launch(13'd44);
        chk("k44_k_err",  32'(k_err), 32'd1);
        chk("k44_busy",   32'(busy),  32'd0);
        chk("k44_K_i",    32'(K_i),   32'd6144);
        step();
        chk("k44_k_err_clear", 32'(k_err), 32'd0);
        launch(13'd6152);
        chk("k6152_k_err", 32'(k_err), 32'd1);
        chk("k6152_busy",  32'(busy),  32'd0);
        chk("k6152_K_i",   32'(K_i),   32'd6144);
        step();
        chk("k6152_k_err_clear", 32'(k_err), 32'd0);
        chk("k6152_busy_after",  32'(busy),  32'd0);
        $display("illegal K=44 and K=6152 checked");

        // K=128 with a stray start at beat 3, then restart timing around DONE
        launch(13'd128);
        run_to_done(300, 128, 3, 13'd40, beats, last_beat, max_cnt, bad, got_done);
        chk("k128_done_seen", 32'(got_done), 32'd1);
        chk("k128_beats",     32'(beats),    32'd16);
        chk("k128_bad",       32'(bad),      32'd0);
        K_in = 13'd40;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_in_done_ignored", 32'(busy), 32'd0);
        launch(13'd40);
        chk("restart_after_done_busy", 32'(busy), 32'd1);
        chk("restart_after_done_K_i",  32'(K_i),  32'd40);
        run_to_done(100, 40, -1, 13'd0, beats, last_beat, max_cnt, bad, got_done);
        chk("restart_beats", 32'(beats), 32'd5);
        chk("restart_bad",   32'(bad),   32'd0);
        $display("run K=128 beats=16 expected, restart K=40 beats=%0d", beats);
        step();

        // Reset mid-run of K=512 at beat 10
        launch(13'd512);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pi_valid && pi_beat == 10'd10) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("k512_reach_beat10", 32'(found), 32'd1);
        rst = 1'b1;
        #1 check_reset_outputs("midrun_rst");
        step();
        check_reset_outputs("midrun_rst_held");
        rst = 1'b0;
        step();
        launch(13'd40);
        run_to_done(100, 40, -1, 13'd0, beats, last_beat, max_cnt, bad, got_done);
        chk("post_rst_done",  32'(got_done), 32'd1);
        chk("post_rst_beats", 32'(beats),    32'd5);
        chk("post_rst_bad",   32'(bad),      32'd0);
        $display("reset during K=512 run, follow-up K=40 beats=%0d", beats);
        step();

`ifdef ILV_ABORT_EN
        begin
            int n_done, n_abt;
            launch(13'd96);
            found = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (pi_valid && pi_beat == 10'd2) begin
                    found = 1'b1;
                    break;
                end
                step();
            end
            chk("abort_reach_beat2", 32'(found), 32'd1);
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("abort_pulse",    32'(aborted),   32'd1);
            chk("abort_pv_low",   32'(pi_valid),  32'd0);
            chk("abort_busy",     32'(busy),      32'd0);
            chk("abort_cnt",      32'(counter_r), 32'd0);
            chk("abort_clr",      32'(dff_clr),   32'd1);
            chk("abort_no_done",  32'(done),      32'd0);
            n_done = 0;
            n_abt  = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (done)    n_done++;
                if (aborted) n_abt++;
            end
            chk("abort_done_after", 32'(n_done), 32'd0);
            chk("abort_single",     32'(n_abt),  32'd0);
            $display("abort during K=96 run checked");
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/interleaver_ctrl.md
Name: interleaver_ctrl

Overview:
Sequencer for the QPP turbo-interleaver address datapath (stage 1 theta/init generation plus stage 2 eight-address recursion).
- Accepts a block length K and a start pulse, validates K, and drives the shared `counter_r` and `dff_clr` into both stages.
- Produces the valid/index/last/done qualifiers telling the downstream memory writer when the eight Pi outputs are meaningful.
- One run yields K/8 output beats: eight addresses per beat, at offsets 0, K/4, K/2 and 3K/4, each for 2n and 2n+1.

Parameters:
- KW, 13, width of K and of address indices.
- CW, 10, width of `counter_r`; max count is 767 (K=6144).
- STAGE1_LAT, 2, cycles stage 1 needs after K is latched before its theta/init outputs are stable (range 1..7).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  single-cycle request; sampled only in IDLE
- K_in  in  KW  requested block length
- K_i  out  KW  latched K fanned out to stage 1 and stage 2
- counter_r  out  CW  beat counter to stage 1 and stage 2
- dff_clr  out  1  clear to the stage 2 registers
- busy  out  1  high from LOAD through DONE inclusive
- pi_valid  out  1  stage 2 Pi outputs hold beat pi_beat this cycle
- pi_beat  out  CW  beat index n; Pi2n output equals Pi(2n)
- pi_last  out  1  qualifies the final beat
- done  out  1  one-cycle pulse after the final beat
- k_err  out  1  one-cycle pulse when start carries an illegal K

Behaviour:
Reset values:
- State IDLE; K_i=0, counter_r=0, dff_clr=1.
- busy, pi_valid, pi_beat, pi_last, done and k_err all 0.

Legal K:
- K_in[2:0]==0 and 40 <= K_in <= 6144.
- No finer LTE step check is made; the table step is the caller's responsibility.

FSM:
- IDLE: dff_clr=1, counter_r=0.
  - start with legal K: go to LOAD and latch K_i.
  - start with illegal K: pulse k_err next cycle, stay IDLE, K_i unchanged.
- LOAD (1 cycle): busy=1, dff_clr=1. Load the wait counter with STAGE1_LAT-1, then go to WAIT.
- WAIT (STAGE1_LAT cycles): dff_clr=0, counter_r=0, then go to RUN.
- RUN (K/8 cycles): counter_r steps 0,1,…,K/8-1, one per cycle.
  - Terminal count is K_i>>3 minus 1, a 10-bit compare.
  - After the cycle with counter_r=K/8-1, go to DONE.
- DONE (1 cycle): done=1, then go to IDLE with counter_r back to 0.

Output latency (stage 2 registers its result):
- pi_valid, pi_beat and pi_last are registered copies of RUN, counter_r and the terminal-count flag, delayed by exactly one cycle.
- The final pi_valid beat therefore coincides with DONE; done and pi_last are high in the same cycle.

Boundary conditions:
- start while busy: ignored, no k_err.
- start in the same cycle as DONE: ignored. The earliest accepted restart is the cycle after DONE.
- K=40: exactly 5 beats.
- K=6144: exactly 768 beats, with counter_r peaking at 767 and no wrap.
- rst asserted mid-run: immediate return to reset values, no done pulse, dff_clr high.
- K_in changes after acceptance: no effect until the next start.

Optional Feature:
Macro ILV_ABORT_EN.
- Defined:
  - Adds input `abort` (1 bit) and output `aborted` (1 bit, reset 0).
  - abort sampled high in LOAD, WAIT or RUN: next cycle state is IDLE, counter_r=0, dff_clr=1, and pi_valid drops.
  - aborted pulses for one cycle; done does not pulse.
  - abort in IDLE or DONE: ignored.
  - abort wins over the terminal-count transition.
- Undefined: neither port exists, and runs always complete.

Decomposition:
- Package `interleaver_pkg` holds:
  - constants KW=13, CW=10, K_MIN=40, K_MAX=6144;
  - state enum {IDLE, LOAD, WAIT, RUN, DONE}.
- The FSM, counters and output pipeline stay in this module. The one-cycle output delay uses the existing generaldff.
- One natural sub-module: `ilv_k_check`, a combinational legality check (K in, legal out), reusable by the stage 1 lookup.

Test Plan:
- K_in=40, start at cycle 0:
  - busy rises at cycle 1, RUN spans cycles 4–8 with counter_r 0..4.
  - pi_valid covers cycles 5–9 with pi_beat 0..4.
  - pi_last and done are both high in cycle 9, busy falls in cycle 10.
- K_in=6144:
  - exactly 768 pi_valid cycles, last pi_beat=767, counter_r never exceeds 767.
  - Pi outputs match the golden QPP model (f1=263, f2=480) for all beats.
- K_in=44, then K_in=6152:
  - k_err pulses each time, busy stays 0, K_i retains its prior value.
- K_in=128 running; at beat 3 start is pulsed with K_in=40:
  - the run completes 16 beats with K_i=128 throughout.
  - a restart is accepted only in the cycle after done.
- rst raised during RUN of K_in=512 at beat 10:
  - all outputs are at reset values while rst is high, with no done.
  - a subsequent K_in=40 run is correct.
- ILV_ABORT_EN defined: abort at beat 2 of K_in=96:
  - aborted pulses once, pi_valid is low the following cycle, done never asserts.
